mem_sequencer: RTL and testbench
================================

# mem_sequencer

Parametrised memory transaction sequencer between the CPU control FSM and the memory/paging unit. It accepts single- or multi-beat read, write and fetch requests. For every beat it checks R/W/X permission against the current page-table entry, runs the MemRRq/MemWRq/MemOK/MemAck handshake with a wait-state timeout, and reports data, completion or a coded fault. It replaces per-state memory sequencing in the control FSM with one reusable engine.

## Interface
- DATA_W, 16: data word width.
- ADDR_W, 16: address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 2: burst length field width; a burst is 1..2^LEN_W beats.
- MAX_WAIT, 15: number of WAIT cycles allowed before a timeout fault; 0 disables the timeout.
- Clk  in  1  clock; all registers update on posedge Clk.
- Rst  in  1  reset, synchronous, active-high.
- ReqValid  in  1  request strobe; sampled only in IDLE.
- ReqReady  out  1  high when in IDLE.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqExec  in  1  instruction-fetch read (X check instead of R); ignored when ReqWrite = 1.
- ReqAddr  in  ADDR_W  start address.
- ReqData  in  DATA_W  write data; first beat sampled with ReqValid, later beats sampled when NextBeat = 1.
- ReqLen  in  LEN_W  beats minus 1.
- PLevel  in  1  0 = privileged, 1 = unprivileged; latched at request.
- NextBeat  out  1  one-cycle pulse requesting the next write beat's data.
- RspValid  out  1  one-cycle pulse; RspData is valid (reads only).
- RspData  out  DATA_W  read data.
- Done  out  1  one-cycle pulse; the whole transaction succeeded.
- Fault  out  1  one-cycle pulse; the transaction was aborted.
- FaultCode  out  2  01 = permission, 10 = timeout; held until the next fault.
- FaultAddr  out  ADDR_W  address of the faulting beat; held until the next fault.
- FaultPriv  out  1  latched PLevel = 0 at the fault; the control FSM resets the core on this.
- MemAddr  out  ADDR_W  beat address; also drives the page-table lookup.
- MemWData  out  DATA_W  write data.
- MemOE  out  1  1 while a write beat drives data.
- MemRRq / MemWRq  out  1  read / write request.
- MemOK  in  1  memory completed the beat.
- MemRData  in  DATA_W  read data; valid when MemOK = 1.
- MemAck  out  1  one-cycle acknowledge after MemOK.
- CurrPTE  in  16  PTE for MemAddr; valid in CHECK. Bit 15 = user R, bit 14 = user W, bit 13 = user X, bit 12 = privileged X.

## Operation
- States: IDLE, CHECK, WAIT, ACK, FAULT.
- **IDLE.**
  - On ReqValid, latch ReqAddr→MemAddr, ReqData→MemWData, Write, Exec, Len, PLevel; BeatCnt = 0; go to CHECK.
  - ReqValid outside IDLE is ignored.
- **CHECK.** Evaluate the permission for the current beat:
  - Exec: privileged needs PTE[12], unprivileged needs PTE[13].
  - Read: privileged always allowed; unprivileged needs PTE[15].
  - Write: privileged always allowed; unprivileged needs PTE[14].
  - Pass: go to WAIT, setting MemRRq = 1, or MemWRq = 1 and MemOE = 1; WaitCnt = 0.
  - Fail: go to FAULT with code 01.
- **WAIT.**
  - MemOK = 1: go to ACK, drop MemRRq/MemWRq/MemOE, set MemAck = 1. For a read, also register MemRData→RspData and set RspValid = 1.
  - MemOK = 0: WaitCnt++. When MAX_WAIT ≠ 0 and WaitCnt reaches MAX_WAIT, go to FAULT with code 10.
- **ACK.**
  - Last beat (BeatCnt = Len): Done = 1, go to IDLE.
  - Otherwise: MemAddr++ (wrapping), BeatCnt++, go to CHECK. Every beat is re-checked, because page crossings are allowed.
  - On a write with beats remaining, NextBeat = 1 in ACK and ReqData is registered to MemWData at that edge.
- **FAULT.** Fault = 1; FaultCode, FaultAddr (= MemAddr) and FaultPriv are registered; go to IDLE. Done is not asserted. Beats already completed are not rolled back.
- **Widths.** BeatCnt is LEN_W bits. WaitCnt is wide enough to hold MAX_WAIT and saturates.

## Timing
- **Outputs.** All outputs are registered.
- **Reset values.** State = IDLE; ReqReady = 1; every strobe and request output = 0; MemAddr, MemWData, RspData, FaultAddr = 0; FaultCode = 00; FaultPriv = 0.
- **Reset mid-transaction.** Rst takes priority over all transitions. MemRRq/MemWRq drop at the reset edge; no Done or Fault is produced.
- **Single-beat latency.** With ReqValid sampled at edge 0: CHECK in cycle 1, WAIT in cycle 2. With MemOK = 1 in cycle 2, RspValid, MemAck and Done are high in cycle 3.
  - Minimum latency: 3 cycles; each wait state adds 1.
- **Burst throughput.** 3 cycles per beat (ACK→CHECK→WAIT) with zero wait states.
- **Timeout.** MemOK is accepted in WAIT cycles 1..MAX_WAIT. If MemOK = 0 through WAIT cycle MAX_WAIT, Fault is high in the next cycle.
- **ReqReady.** Rises in the cycle after Done or Fault; a new request may be sampled in that cycle.
- **Requests during ACK/FAULT.** MemRRq/MemWRq are 0; a request is never held across beats.

## Test plan
- Privileged read at 0x0010, PTE = 0, MemOK in the first WAIT cycle, MemRData = 0xBEEF → RspValid, MemAck and Done all in cycle 3; RspData = 0xBEEF.
- Unprivileged 4-beat write at 0xFFFE, PTE[14] = 1, data A1..A4 → MemAddr sequence FFFE, FFFF, 0000, 0001; MemWData matches each beat; 3 NextBeat pulses; Done after beat 4.
- Unprivileged fetch with PTE[13] = 0 → no MemRRq; Fault in cycle 2 with FaultCode = 01, FaultAddr = ReqAddr, FaultPriv = 0.
- MAX_WAIT = 15, MemOK held at 0 → MemRRq high for exactly 15 cycles, then Fault with FaultCode = 10. Repeat with MemOK in WAIT cycle 15 → success.
- Rst asserted in WAIT of beat 2 of 3 → MemRRq is 0 after the edge, state is IDLE, no Done or Fault; a new request then completes normally.

Source files
------------

// File: rtl/mem_sequencer.sv
// Memory transaction sequencer: per-beat permission check, MemOK/MemAck
// handshake with wait-state timeout, and coded fault reporting.
module mem_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int LEN_W    = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic              ReqExec,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    input  logic [LEN_W-1:0]  ReqLen,
    input  logic              PLevel,
    output logic              NextBeat,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              Done,
    output logic              Fault,
    output logic [1:0]        FaultCode,
    output logic [ADDR_W-1:0] FaultAddr,
    output logic              FaultPriv,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemOE,
    output logic              MemRRq,
    output logic              MemWRq,
    input  logic              MemOK,
    input  logic [DATA_W-1:0] MemRData,
    output logic              MemAck,
    input  logic [15:0]       CurrPTE
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT,
        ACK,
        FAULT
    } state_t;

    state_t             state;
    logic               isWrite;
    logic               isExec;
    logic               pLevel;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   beatCnt;
    logic [WAIT_W-1:0]  waitCnt;
    logic               permOk;
    logic               lastBeat;

    assign lastBeat = (beatCnt == len);

    // Privileged reads/writes are always allowed; fetches always need an X bit.
    always_comb begin
        permOk = 1'b0;
        unique case (1'b1)
            isExec:  permOk = pLevel ? CurrPTE[13] : CurrPTE[12];
            isWrite: permOk = ~pLevel | CurrPTE[14];
            default: permOk = ~pLevel | CurrPTE[15];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            ReqReady  <= 1'b1;
            NextBeat  <= 1'b0;
            RspValid  <= 1'b0;
            RspData   <= '0;
            Done      <= 1'b0;
            Fault     <= 1'b0;
            FaultCode <= 2'b00;
            FaultAddr <= '0;
            FaultPriv <= 1'b0;
            MemAddr   <= '0;
            MemWData  <= '0;
            MemOE     <= 1'b0;
            MemRRq    <= 1'b0;
            MemWRq    <= 1'b0;
            MemAck    <= 1'b0;
            isWrite   <= 1'b0;
            isExec    <= 1'b0;
            pLevel    <= 1'b0;
            len       <= '0;
            beatCnt   <= '0;
            waitCnt   <= '0;
        end else begin
            NextBeat <= 1'b0;
            RspValid <= 1'b0;
            Done     <= 1'b0;
            Fault    <= 1'b0;
            MemAck   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        MemAddr  <= ReqAddr;
                        MemWData <= ReqData;
                        isWrite  <= ReqWrite;
                        isExec   <= ReqExec & ~ReqWrite;
                        len      <= ReqLen;
                        pLevel   <= PLevel;
                        beatCnt  <= '0;
                        ReqReady <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (permOk) begin
                        MemRRq  <= ~isWrite;
                        MemWRq  <= isWrite;
                        MemOE   <= isWrite;
                        waitCnt <= '0;
                        state   <= WAIT;
                    end else begin
                        Fault     <= 1'b1;
                        FaultCode <= 2'b01;
                        FaultAddr <= MemAddr;
                        FaultPriv <= ~pLevel;
                        state     <= FAULT;
                    end
                end
                WAIT: begin
                    if (MemOK) begin
                        MemRRq <= 1'b0;
                        MemWRq <= 1'b0;
                        MemOE  <= 1'b0;
                        MemAck <= 1'b1;
                        if (!isWrite) begin
                            RspData  <= MemRData;
                            RspValid <= 1'b1;
                        end
                        Done     <= lastBeat;
                        NextBeat <= isWrite & ~lastBeat;
                        state    <= ACK;
                    end else if ((MAX_WAIT != 0) && (waitCnt == WAIT_LAST)) begin
                        MemRRq    <= 1'b0;
                        MemWRq    <= 1'b0;
                        MemOE     <= 1'b0;
                        Fault     <= 1'b1;
                        FaultCode <= 2'b10;
                        FaultAddr <= MemAddr;
                        FaultPriv <= ~pLevel;
                        state     <= FAULT;
                    end else if (waitCnt != '1) begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ACK: begin
                    if (lastBeat) begin
                        ReqReady <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        MemAddr <= MemAddr + 1'b1;
                        beatCnt <= beatCnt + 1'b1;
                        if (isWrite) begin
                            MemWData <= ReqData;
                        end
                        state <= CHECK;
                    end
                end
                FAULT: begin
                    ReqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    ReqReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: per-transaction cycle timeline model,
// randomized traffic plus directed literal checks.
module tb_mem_sequencer;

    localparam int MAX_WAIT = 15;

    logic        Clk;
    logic        Rst;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic        ReqExec;
    logic [15:0] ReqAddr;
    logic [15:0] ReqData;
    logic [1:0]  ReqLen;
    logic        PLevel;
    logic        NextBeat;
    logic        RspValid;
    logic [15:0] RspData;
    logic        Done;
    logic        Fault;
    logic [1:0]  FaultCode;
    logic [15:0] FaultAddr;
    logic        FaultPriv;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemOE;
    logic        MemRRq;
    logic        MemWRq;
    logic        MemOK;
    logic [15:0] MemRData;
    logic        MemAck;
    logic [15:0] CurrPTE;

    mem_sequencer #(
        .DATA_W(16), .ADDR_W(16), .LEN_W(2), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqExec(ReqExec),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqLen(ReqLen),
        .PLevel(PLevel), .NextBeat(NextBeat),
        .RspValid(RspValid), .RspData(RspData),
        .Done(Done), .Fault(Fault), .FaultCode(FaultCode),
        .FaultAddr(FaultAddr), .FaultPriv(FaultPriv),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemOE(MemOE),
        .MemRRq(MemRRq), .MemWRq(MemWRq), .MemOK(MemOK),
        .MemRData(MemRData), .MemAck(MemAck), .CurrPTE(CurrPTE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst, valid, write, exec, plevel, memOk;
        logic [1:0]  len;
        logic [15:0] addr, data, rdata, pte;
    } drv_t;

    typedef struct packed {
        logic        rdy, rrq, wrq, oe, ack, rv, done, flt, nb, fpriv;
        logic [1:0]  fcode;
        logic [15:0] addr, wdata, rdata, faddr;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;

    // Values the DUT holds between transactions
    logic [15:0] hAddr, hWData, hRData, hFAddr;
    logic [1:0]  hFCode;
    logic        hFPriv;

    logic [15:0] tDat[4];
    logic [15:0] tRd[4];
    logic [15:0] tPte[4];
    int          tWait[4];

    drv_t dq[$];
    obs_t eq[$];

    int doneIdx, faultIdx, rvIdx, rrqCnt, nbCnt, doneCnt, faultCnt;
    logic [15:0] lastRsp, lastFAddr;
    logic [1:0]  lastFCode;
    logic        lastFPriv;
    logic [15:0] ackAddr[$];
    logic [15:0] ackWData[$];

    function automatic drv_t junk();
        drv_t d;
        d.rst    = 1'b0;
        d.valid  = 1'($urandom);
        d.write  = 1'($urandom);
        d.exec   = 1'($urandom);
        d.plevel = 1'($urandom);
        d.memOk  = 1'($urandom);
        d.len    = 2'($urandom);
        d.addr   = 16'($urandom);
        d.data   = 16'($urandom);
        d.rdata  = 16'($urandom);
        d.pte    = 16'($urandom);
        return d;
    endfunction

    function automatic obs_t base(input logic rdy);
        obs_t e;
        e       = '0;
        e.rdy   = rdy;
        e.addr  = hAddr;
        e.wdata = hWData;
        e.rdata = hRData;
        e.fcode = hFCode;
        e.faddr = hFAddr;
        e.fpriv = hFPriv;
        return e;
    endfunction

    task automatic zeroHolds();
        hAddr  = '0;
        hWData = '0;
        hRData = '0;
        hFAddr = '0;
        hFCode = 2'b00;
        hFPriv = 1'b0;
    endtask

    task automatic clrObs();
        doneIdx  = -1;
        faultIdx = -1;
        rvIdx    = -1;
        rrqCnt   = 0;
        nbCnt    = 0;
        doneCnt  = 0;
        faultCnt = 0;
        lastRsp  = '0;
        lastFAddr = '0;
        lastFCode = 2'b00;
        lastFPriv = 1'b0;
        ackAddr.delete();
        ackWData.delete();
    endtask

    task automatic drive(input drv_t d);
        Rst      = d.rst;
        ReqValid = d.valid;
        ReqWrite = d.write;
        ReqExec  = d.exec;
        PLevel   = d.plevel;
        MemOK    = d.memOk;
        ReqLen   = d.len;
        ReqAddr  = d.addr;
        ReqData  = d.data;
        MemRData = d.rdata;
        CurrPTE  = d.pte;
    endtask

    task automatic cycle(input drv_t d, input obs_t e, input int idx);
        obs_t act;
        drive(d);
        @(negedge Clk);
        act.rdy   = ReqReady;
        act.rrq   = MemRRq;
        act.wrq   = MemWRq;
        act.oe    = MemOE;
        act.ack   = MemAck;
        act.rv    = RspValid;
        act.done  = Done;
        act.flt   = Fault;
        act.nb    = NextBeat;
        act.fpriv = FaultPriv;
        act.fcode = FaultCode;
        act.addr  = MemAddr;
        act.wdata = MemWData;
        act.rdata = RspData;
        act.faddr = FaultAddr;
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL cycle idx=%0d t=%0t got=%h want=%h", idx, $time, act, e);
        end
        if (act.done) begin doneIdx = idx; doneCnt++; end
        if (act.flt) begin
            faultIdx  = idx;
            faultCnt++;
            lastFCode = act.fcode;
            lastFAddr = act.faddr;
            lastFPriv = act.fpriv;
        end
        if (act.rv) begin rvIdx = idx; lastRsp = act.rdata; end
        if (act.rrq) rrqCnt++;
        if (act.nb) nbCnt++;
        if (act.ack) begin
            ackAddr.push_back(act.addr);
            ackWData.push_back(act.wdata);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idleCycle();
        drv_t d;
        d = junk();
        d.valid = 1'b0;
        cycle(d, base(1'b1), -1);
    endtask

    task automatic push(input drv_t d, input obs_t e);
        dq.push_back(d);
        eq.push_back(e);
    endtask

    task automatic addFault(input logic [1:0] code, input logic [15:0] a,
                            input logic pl);
        obs_t e;
        hFCode = code;
        hFAddr = a;
        hFPriv = ~pl;
        e = base(1'b0);
        e.flt = 1'b1;
        push(junk(), e);
    endtask

    // Builds the expected cycle timeline of one transaction, then plays it.
    task automatic runTxn(input logic wr, input logic ex, input logic pl,
                          input logic [1:0] len, input logic [15:0] a0,
                          input int rstAt);
        drv_t d;
        obs_t e;
        logic [15:0] a;
        logic isEx, ok, tmo;
        int n;
        dq.delete();
        eq.delete();
        isEx = ex & ~wr;
        d = junk();
        d.valid  = 1'b1;
        d.write  = wr;
        d.exec   = ex;
        d.plevel = pl;
        d.len    = len;
        d.addr   = a0;
        d.data   = tDat[0];
        push(d, base(1'b1));
        hAddr  = a0;
        hWData = tDat[0];
        for (int b = 0; b <= int'(len); b++) begin
            a = a0 + 16'(b);
            d = junk();
            d.pte = tPte[b];
            push(d, base(1'b0));
            if (isEx) ok = pl ? tPte[b][13] : tPte[b][12];
            else      ok = !pl || (wr ? tPte[b][14] : tPte[b][15]);
            if (!ok) begin
                addFault(2'b01, a, pl);
                break;
            end
            tmo = (MAX_WAIT != 0) && (tWait[b] >= MAX_WAIT);
            n = tmo ? MAX_WAIT : tWait[b] + 1;
            for (int k = 0; k < n; k++) begin
                d = junk();
                d.memOk = !tmo && (k == n - 1);
                d.rdata = tRd[b];
                e = base(1'b0);
                e.rrq = !wr;
                e.wrq = wr;
                e.oe  = wr;
                push(d, e);
            end
            if (tmo) begin
                addFault(2'b10, a, pl);
                break;
            end
            if (!wr) hRData = tRd[b];
            d = junk();
            if (wr && b < int'(len)) d.data = tDat[b + 1];
            e = base(1'b0);
            e.ack  = 1'b1;
            e.rv   = !wr;
            e.nb   = wr && (b < int'(len));
            e.done = (b == int'(len));
            push(d, e);
            if (b < int'(len)) begin
                hAddr = a + 16'd1;
                if (wr) hWData = tDat[b + 1];
            end
        end
        d = junk();
        d.valid = 1'b0;
        push(d, base(1'b1));
        clrObs();
        for (int i = 0; i < dq.size(); i++) begin
            d = dq[i];
            if (i == rstAt) d.rst = 1'b1;
            cycle(d, eq[i], i);
            if (i == rstAt) break;
        end
        if (rstAt >= 0 && rstAt < dq.size()) begin
            zeroHolds();
            idleCycle();
        end
    endtask

    task automatic setBeats(input logic [15:0] pte, input int w);
        for (int b = 0; b < 4; b++) begin
            tDat[b]  = 16'($urandom);
            tRd[b]   = 16'($urandom);
            tPte[b]  = pte;
            tWait[b] = w;
        end
    endtask

    initial begin
        drv_t d;
        logic wr, ex, pl;
        logic [1:0] len;
        logic [15:0] a0;
        int r, rstAt;

        zeroHolds();
        d = junk();
        d.rst   = 1'b1;
        d.valid = 1'b1;
        drive(d);
        repeat (2) @(posedge Clk);
        #1;
        idleCycle();
        lit("reset_ready", int'(ReqReady), 1);

        // Privileged single read, MemOK in first WAIT cycle
        setBeats(16'h0000, 0);
        tRd[0] = 16'hBEEF;
        runTxn(1'b0, 1'b0, 1'b0, 2'd0, 16'h0010, -1);
        lit("rd_done_idx", doneIdx, 3);
        lit("rd_rv_idx", rvIdx, 3);
        lit("rd_data", int'(lastRsp), 32'hBEEF);
        lit("rd_acks", ackAddr.size(), 1);

        // Unprivileged 4-beat write wrapping through 0xFFFF
        setBeats(16'h4000, 0);
        for (int b = 0; b < 4; b++) tDat[b] = 16'h00A1 + 16'(b);
        runTxn(1'b1, 1'b0, 1'b1, 2'd3, 16'hFFFE, -1);
        lit("wr_beats", ackAddr.size(), 4);
        if (ackAddr.size() == 4) begin
            lit("wr_addr0", int'(ackAddr[0]), 32'hFFFE);
            lit("wr_addr1", int'(ackAddr[1]), 32'hFFFF);
            lit("wr_addr2", int'(ackAddr[2]), 32'h0000);
            lit("wr_addr3", int'(ackAddr[3]), 32'h0001);
            lit("wr_data0", int'(ackWData[0]), 32'h00A1);
            lit("wr_data3", int'(ackWData[3]), 32'h00A4);
        end
        lit("wr_nextbeats", nbCnt, 3);
        lit("wr_done_idx", doneIdx, 12);

        // Unprivileged fetch without user X
        setBeats(16'hD000, 0);
        runTxn(1'b0, 1'b1, 1'b1, 2'd0, 16'h1234, -1);
        lit("fx_rrq", rrqCnt, 0);
        lit("fx_fault_idx", faultIdx, 2);
        lit("fx_code", int'(lastFCode), 1);
        lit("fx_addr", int'(lastFAddr), 32'h1234);
        lit("fx_priv", int'(lastFPriv), 0);

        // Timeout, then success on the last allowed WAIT cycle
        setBeats(16'h0000, 100);
        runTxn(1'b0, 1'b0, 1'b0, 2'd0, 16'h0400, -1);
        lit("to_rrq", rrqCnt, 15);
        lit("to_fault_idx", faultIdx, 17);
        lit("to_code", int'(lastFCode), 2);
        lit("to_priv", int'(lastFPriv), 1);
        setBeats(16'h0000, 14);
        runTxn(1'b0, 1'b0, 1'b0, 2'd0, 16'h0400, -1);
        lit("w15_done_idx", doneIdx, 17);
        lit("w15_rrq", rrqCnt, 15);

        // Reset in WAIT of beat 2 of 3, then a normal request
        setBeats(16'h0000, 0);
        tWait[1] = 3;
        runTxn(1'b0, 1'b0, 1'b0, 2'd2, 16'h2000, 5);
        lit("rst_done", doneCnt, 0);
        lit("rst_fault", faultCnt, 0);
        lit("rst_rrq_after", int'(MemRRq), 0);
        setBeats(16'h0000, 0);
        runTxn(1'b0, 1'b0, 1'b0, 2'd0, 16'h0033, -1);
        lit("post_rst_done_idx", doneIdx, 3);

        repeat (300) begin
            wr  = 1'($urandom);
            ex  = 1'($urandom);
            pl  = 1'($urandom);
            len = 2'($urandom);
            if ($urandom_range(0, 3) == 0) a0 = 16'hFFFD + 16'($urandom_range(0, 2));
            else a0 = 16'($urandom);
            for (int b = 0; b < 4; b++) begin
                tDat[b] = 16'($urandom);
                tRd[b]  = 16'($urandom);
                if ($urandom_range(0, 4) == 0) tPte[b] = 16'($urandom);
                else tPte[b] = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
                r = $urandom_range(0, 19);
                if (r < 14) tWait[b] = r % 4;
                else if (r < 16) tWait[b] = 14;
                else if (r < 18) tWait[b] = 13;
                else tWait[b] = MAX_WAIT + $urandom_range(0, 2);
            end
            rstAt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 8) : -1;
            runTxn(wr, ex, pl, len, a0, rstAt);
            repeat ($urandom_range(0, 2)) idleCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
